// File: rtl/sys_types.sv
// Shared scalar types and requantization parameter bundle for the output datapath.
package sys_types;

  typedef logic signed [7:0]  int8_t;
  typedef logic signed [31:0] int32_t;
  typedef logic signed [63:0] int64_t;

  typedef struct packed {
    int32_t     mult;
    logic [4:0] shift;
    int8_t      zp;
  } requant_params_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  localparam int8_t INT8_MIN = -8'sd128;
  localparam int8_t INT8_MAX = 8'sd127;

endpackage

// File: rtl/requant_pipe.sv
// Three-stage int32 -> int8 requantizer: Q31 multiply, rounding shift, zero point + clamp.
module requant_pipe
  import sys_types::*;
#(
  parameter int DATA_W = 32,
  parameter int COEF_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     adv,
  input  logic                     in_vld,
  input  logic signed [DATA_W-1:0] in_acc,
  input  logic [IDX_W-1:0]         in_idx,
  input  logic                     in_last,
  input  requant_params_t          prm,
  output logic                     out_valid,
  output logic signed [7:0]        out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [PROD_W-1:0] MUL_HALF = PROD_W'(1) <<< (COEF_W - 2);
  localparam logic signed [PROD_W-1:0] DATA_MAX = PROD_W'({1'b0, {(DATA_W-1){1'b1}}});

  // Only MIN*MIN can exceed the positive range after rounding; it saturates.
  function automatic logic signed [DATA_W-1:0] mul_round(input logic signed [DATA_W-1:0] a,
                                                          input logic signed [COEF_W-1:0] m);
    logic signed [PROD_W-1:0] q;
    q = a * m;
    q = (q + MUL_HALF) >>> (COEF_W - 1);
    if (q > DATA_MAX) return {1'b0, {(DATA_W-1){1'b1}}};
    return q[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W:0] shift_round(input logic signed [DATA_W-1:0] v,
                                                          input logic [4:0] sh);
    logic signed [DATA_W:0] x;
    logic signed [DATA_W:0] rnd;
    x = v;
    if (sh == 5'd0) return x;
    rnd = '0;
    rnd[sh - 5'd1] = 1'b1;
    x = x + rnd;
    return x >>> sh;
  endfunction

  function automatic int8_t sat_int8(input logic signed [DATA_W:0] r, input int8_t zp);
    logic signed [DATA_W+1:0] s;
    s = r + zp;
    if (s < INT8_MIN) return INT8_MIN;
    if (s > INT8_MAX) return INT8_MAX;
    return s[7:0];
  endfunction

  logic                     vld_p0, vld_p1, vld_p2;
  logic signed [DATA_W-1:0] hi_p0;
  logic signed [DATA_W:0]   r_p1;
  int8_t                    data_p2;
  logic [IDX_W-1:0]         idx_p0, idx_p1, idx_p2;
  logic                     last_p0, last_p1, last_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= in_vld;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // p0: fixed-point multiply; p1: rounding shift
  always_ff @(posedge clk) begin
    if (adv) begin
      hi_p0   <= mul_round(in_acc, prm.mult);
      idx_p0  <= in_idx;
      last_p0 <= in_last;
      r_p1    <= shift_round(hi_p0, prm.shift);
      idx_p1  <= idx_p0;
      last_p1 <= last_p0;
    end
  end

  // p2: zero point and clamp, doubles as the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p2 <= '0;
      idx_p2  <= '0;
      last_p2 <= 1'b0;
    end else if (adv) begin
      data_p2 <= sat_int8(r_p1, prm.zp);
      idx_p2  <= idx_p1;
      last_p2 <= last_p1;
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_idx   = idx_p2;
  assign out_last  = last_p2;

endmodule

// File: rtl/acc_drain_requant.sv
// Snapshots the accumulator array on a drain command and streams requantized int8 beats.
module acc_drain_requant
  import sys_types::*;
#(
  parameter int N_ACC = 16,
  parameter int IDX_W = $clog2(N_ACC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  drain_start,
  input  logic [N_ACC*32-1:0]   acc_in,
  input  logic signed [31:0]    mult_in,
  input  logic [4:0]            shift_in,
  input  logic signed [7:0]     zp_in,
  output logic                  acc_clear,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [7:0]     out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last
);

  localparam logic [IDX_W:0]   BEATS    = (IDX_W + 1)'(N_ACC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ACC - 1);

  drain_state_t    state, state_next;
  logic [IDX_W:0]  issue_cnt;
  int32_t          shadow_acc [N_ACC];
  requant_params_t shadow_prm;
  logic            adv, capture, issue, issue_last;

  always_comb begin
    adv        = !out_valid || out_ready;
    capture    = (state == IDLE) && drain_start;
    issue      = (state == DRAIN) && (issue_cnt < BEATS) && adv;
    issue_last = (issue_cnt[IDX_W-1:0] == LAST_IDX);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (drain_start) state_next = DRAIN;
      DRAIN:   if (out_valid && out_ready && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      issue_cnt <= '0;
      acc_clear <= 1'b0;
    end else begin
      state     <= state_next;
      acc_clear <= capture;
      if (capture) issue_cnt <= '0;
      else if (issue) issue_cnt <= issue_cnt + 1'b1;
    end
  end

  // Shadow copy frees the array to reload bias while the drain proceeds.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N_ACC; i++) shadow_acc[i] <= acc_in[32*i +: 32];
      shadow_prm <= '{mult: mult_in, shift: shift_in, zp: zp_in};
    end
  end

  assign busy = (state == DRAIN);

  requant_pipe #(
    .DATA_W (32),
    .COEF_W (32),
    .IDX_W  (IDX_W)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .adv       (adv),
    .in_vld    (issue),
    .in_acc    (shadow_acc[issue_cnt[IDX_W-1:0]]),
    .in_idx    (issue_cnt[IDX_W-1:0]),
    .in_last   (issue_last),
    .prm       (shadow_prm),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_acc_drain_requant.sv
// Directed plus randomized drains checked against an arithmetic requantization model.
module tb_acc_drain_requant;

  localparam int N   = 16;
  localparam int ALL = 99;

  logic              clk = 1'b0;
  logic              reset;
  logic              drain_start;
  logic [N*32-1:0]   acc_in;
  logic signed [31:0] mult_in;
  logic [4:0]        shift_in;
  logic signed [7:0] zp_in;
  logic              acc_clear, busy, out_valid, out_ready, out_last;
  logic signed [7:0] out_data;
  logic [3:0]        out_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_arr [N];
  int mult_v, shift_v, zp_v;

  acc_drain_requant #(.N_ACC(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .drain_start (drain_start),
    .acc_in      (acc_in),
    .mult_in     (mult_in),
    .shift_in    (shift_in),
    .zp_in       (zp_in),
    .acc_clear   (acc_clear),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Requantization straight from the arithmetic definition, in 64-bit integers.
  function automatic int ref_q(input int a, input int m, input int sh, input int zp);
    longint p, hi, r, s;
    p = longint'(a) * longint'(m);
    if (a == int'(32'h8000_0000) && m == int'(32'h8000_0000)) hi = 64'sd2147483647;
    else hi = longint'(int'((p + 64'sd1073741824) >>> 31));
    if (sh == 0) r = hi;
    else r = (hi + (64'sd1 <<< (sh - 1))) >>> sh;
    s = r + longint'(zp);
    if (s < -128) s = -128;
    if (s > 127) s = 127;
    return int'(s);
  endfunction

  function automatic logic ready_at(input int mode, input int cyc);
    if (mode == 1) return !(cyc >= 6 && cyc <= 9);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) acc_in[32*i +: 32] = $urandom;
    mult_in  = $urandom;
    shift_in = 5'($urandom);
    zp_in    = 8'($urandom);
  endtask

  task automatic do_drain(input int mode, input bit mid_pulse, input bit end_pulse,
                          input int reset_at, input int pin_idx, input int pin_val);
    int exp_q [N];
    int cyc, beat;
    bit held, done;
    logic signed [7:0] hold_d;
    logic [3:0] hold_i;
    for (int i = 0; i < N; i++) exp_q[i] = ref_q(acc_arr[i], mult_v, shift_v, zp_v);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) acc_in[32*i +: 32] = acc_arr[i];
    mult_in     = mult_v;
    shift_in    = 5'(shift_v);
    zp_in       = 8'(zp_v);
    drain_start = 1'b1;
    out_ready   = ready_at(mode, 0);
    chk("clear_T", acc_clear, 0);
    cyc = 0; beat = 0; held = 0; done = 0;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      drain_start = 1'b0;
      scramble_inputs();
      if (mid_pulse && cyc == 7) drain_start = 1'b1;
      if (mid_pulse && cyc == 8) chk("mid_start_clear", acc_clear, 0);
      if (cyc == 1) begin
        chk("clear_T1", acc_clear, 1);
        chk("busy_T1", busy, 1);
      end
      if (cyc == 2) chk("clear_T2", acc_clear, 0);
      if (cyc == 2 || cyc == 3) chk("early_valid", out_valid, 0);
      if (cyc == 4) chk("first_valid_T4", out_valid, 1);
      if (held) begin
        chk("stall_data", $signed(out_data), $signed(hold_d));
        chk("stall_idx", out_idx, hold_i);
        held = 0;
      end
      out_ready = ready_at(mode, cyc);
      if (out_valid) begin
        if (reset_at == beat) begin
          reset = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0;
          chk("rst_mid_valid", out_valid, 0);
          chk("rst_mid_busy", busy, 0);
          chk("rst_mid_data", $signed(out_data), 0);
          chk("rst_mid_idx", out_idx, 0);
          chk("rst_mid_last", out_last, 0);
          return;
        end
        chk("beat_idx", out_idx, beat);
        chk("beat_data", $signed(out_data), exp_q[beat]);
        chk("beat_last", out_last, (beat == N - 1));
        if (pin_idx == ALL || pin_idx == beat) chk("pinned_data", $signed(out_data), pin_val);
        if (out_ready) begin
          if (beat == N - 1) begin
            chk("busy_at_last", busy, 1);
            if (end_pulse) drain_start = 1'b1;
            done = 1;
          end
          beat++;
        end else begin
          held   = 1;
          hold_d = out_data;
          hold_i = out_idx;
        end
      end
      if (!done && cyc > 300) begin
        chk("drain_timeout", beat, N);
        return;
      end
    end
    @(posedge clk); #1;
    drain_start = 1'b0;
    chk("busy_after", busy, 0);
    chk("valid_after", out_valid, 0);
    chk("clear_after", acc_clear, 0);
  endtask

  task automatic fill_small();
    for (int i = 0; i < N; i++) acc_arr[i] = int'($urandom_range(0, 20000)) - 10000;
  endtask

  initial begin
    reset = 1'b1; drain_start = 1'b0; out_ready = 1'b0;
    acc_in = '0; mult_in = '0; shift_in = '0; zp_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clear", acc_clear, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", $signed(out_data), 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    reset = 1'b0;

    fill_small(); acc_arr[0] = 1000;
    mult_v = 32'h4000_0000; shift_v = 2; zp_v = 0;
    do_drain(0, 0, 0, -1, 0, 125);

    fill_small(); acc_arr[1] = 100000; acc_arr[2] = -100000;
    mult_v = 32'h7FFF_FFFF; shift_v = 0; zp_v = 10;
    do_drain(0, 0, 0, -1, 1, 127);
    do_drain(0, 0, 0, -1, 2, -128);

    fill_small(); acc_arr[3] = -3;
    mult_v = 32'h4000_0000; shift_v = 0; zp_v = -5;
    do_drain(0, 0, 0, -1, 3, -6);

    fill_small(); acc_arr[4] = int'(32'h8000_0000);
    mult_v = int'(32'h8000_0000); shift_v = 24; zp_v = 0;
    do_drain(0, 0, 0, -1, 4, 127);

    for (int i = 0; i < N; i++) acc_arr[i] = 4 * i;
    mult_v = 32'h4000_0000; shift_v = 1; zp_v = 0;
    do_drain(1, 1, 1, -1, 15, 15);

    fill_small();
    mult_v = 32'h2000_0000; shift_v = 3; zp_v = 1;
    do_drain(0, 0, 0, 4, -1, 0);

    for (int i = 0; i < N; i++) acc_arr[i] = 0;
    mult_v = 32'h4000_0000; shift_v = 0; zp_v = 7;
    do_drain(0, 0, 0, -1, ALL, 7);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) acc_arr[i] = int'($urandom_range(0, 400000)) - 200000;
      mult_v  = int'($urandom_range(32'h0100_0000, 32'h7FFF_FFFF));
      if ($urandom_range(0, 1) == 1) mult_v = -mult_v;
      shift_v = int'($urandom_range(0, 16));
      zp_v    = int'($urandom_range(0, 255)) - 128;
      do_drain(2, 0, 0, -1, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
